// File: rtl/dma_job_arb_pkg.sv
// Shared helpers for the DMA job arbiter: index-width function and
// protocol-error message strings. Request/response types stay parameters
// of the modules, so nothing type-dependent lives here.
package dma_job_arb_pkg;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam string MsgRspEmpty      = "dma_job_arbiter: backend response with no job in flight";
  localparam string MsgCntUnderflow  = "dma_job_arbiter: per-requester in-flight counter underflow";

endpackage

// File: rtl/dma_job_arb_owner_fifo.sv
// In-order FIFO holding the requester index of every job the backend has
// accepted. Head is read combinationally so the response path can route
// in the same cycle the response arrives.
module dma_job_arb_owner_fifo
  import dma_job_arb_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned Width    = 2,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o
);

  localparam int unsigned PtrWidth = idx_width(Depth);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] usage_q, usage_d;

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
  end

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (usage_q == CntWidth'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;

endmodule

// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter sharing one iDMA burst backend between NumReq
// requesters. Owners of accepted jobs are queued in order so each backend
// response is steered back to the requester that issued it.
// Optional build macro DMA_JOB_ARB_PRIO_EN adds prio_i: requesters with
// their prio bit set are served first, with a single shared RR pointer.
module dma_job_arbiter
  import dma_job_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxInFlight = 8,
  parameter type         idma_req_t  = logic,
  parameter type         idma_rsp_t  = logic,
  localparam int unsigned IdxWidth   = idx_width(NumReq),
  localparam int unsigned CntWidth   = $clog2(MaxInFlight + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  idma_req_t           req_i [NumReq],
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
`ifdef DMA_JOB_ARB_PRIO_EN
  input  logic [NumReq-1:0]   prio_i,
`endif
  output idma_rsp_t           rsp_o,
  output logic [NumReq-1:0]   rsp_valid_o,
  input  logic [NumReq-1:0]   rsp_ready_i,
  output idma_req_t           be_req_o,
  output logic                be_valid_o,
  input  logic                be_ready_i,
  input  idma_rsp_t           be_rsp_i,
  input  logic                be_rsp_valid_i,
  output logic                be_rsp_ready_o,
  output logic [NumReq-1:0]   busy_o,
  output logic [CntWidth-1:0] inflight_o
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;

  logic [NumReq-1:0]   cand;
  logic                rr_found;
  logic [IdxWidth-1:0] rr_idx;
  logic [IdxWidth-1:0] scan_idx;
  logic [IdxWidth-1:0] grant_idx;
  logic                grant_vld;
  logic                handshake;

  logic                fifo_full;
  logic                fifo_empty;
  logic [IdxWidth-1:0] head_idx;
  logic                pop;

  // Candidate set: prioritised requesters if any are valid, else everyone.
  always_comb begin
    cand = req_valid_i;
`ifdef DMA_JOB_ARB_PRIO_EN
    if (|(req_valid_i & prio_i)) begin
      cand = req_valid_i & prio_i;
    end
`endif
  end

  // Round-robin scan starting at the pointer; first candidate wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < int'(NumReq); k++) begin
      scan_idx = IdxWidth'((int'(ptr_q) + k) % int'(NumReq));
      if (!rr_found && cand[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  // A stalled grant is held so the backend sees a stable request.
  assign grant_idx = lock_q ? lock_idx_q : rr_idx;
  assign grant_vld = lock_q ? req_valid_i[lock_idx_q] : rr_found;
  assign be_valid_o = grant_vld & ~fifo_full;
  assign be_req_o   = req_i[grant_idx];
  assign handshake  = be_valid_o & be_ready_i;

  // Pointer advance on handshake; lock taken while the backend stalls.
  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (handshake) begin
      ptr_d  = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
      lock_d = 1'b0;
    end else if (be_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant_idx;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  dma_job_arb_owner_fifo #(
    .Depth    (MaxInFlight),
    .Width    (IdxWidth),
    .CntWidth (CntWidth)
  ) i_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (grant_idx),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (inflight_o)
  );

  // Responses arrive in job order, so the FIFO head names their owner.
  assign rsp_o          = be_rsp_i;
  assign be_rsp_ready_o = ~fifo_empty & rsp_ready_i[head_idx];
  assign pop            = be_rsp_valid_i & be_rsp_ready_o;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                inc, dec;

    assign req_ready_o[gi] = handshake && (grant_idx == IdxWidth'(gi));
    assign rsp_valid_o[gi] = be_rsp_valid_i && !fifo_empty && (head_idx == IdxWidth'(gi));
    assign inc = handshake && (grant_idx == IdxWidth'(gi));
    assign dec = pop && (head_idx == IdxWidth'(gi));

    // Per-requester in-flight count; push and pop on one owner cancel.
    always_comb begin
      cnt_d = cnt_q;
      case ({inc, dec})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign busy_o[gi] = (cnt_q != '0);

`ifndef SYNTHESIS
    // Flag a pop against a requester that has nothing outstanding.
    always @(posedge clk_i) begin
      if (rst_ni) begin
        assert (!(dec && !inc && cnt_q == '0)) else $warning("%s", MsgCntUnderflow);
      end
    end
`endif
  end

`ifndef SYNTHESIS
  // Flag a backend response arriving while no job is outstanding.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(be_rsp_valid_i && fifo_empty)) else $warning("%s", MsgRspEmpty);
    end
  end
`endif

endmodule

// File: tb/tb_dma_job_arbiter.sv
// Directed bench for dma_job_arbiter (NumReq=4, MaxInFlight=8, 16-bit
// request/response payloads). Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_dma_job_arbiter;

  localparam int NumReq = 4;
  localparam int MaxInFlight = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] req [NumReq];
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  prio;
  logic [15:0] rsp;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [15:0] be_req;
  logic        be_valid;
  logic        be_ready;
  logic [15:0] be_rsp;
  logic        be_rsp_valid;
  logic        be_rsp_ready;
  logic [3:0]  busy;
  logic [3:0]  inflight;

  int checks = 0;
  int fails  = 0;

  dma_job_arbiter #(
    .NumReq      (NumReq),
    .MaxInFlight (MaxInFlight),
    .idma_req_t  (logic [15:0]),
    .idma_rsp_t  (logic [15:0])
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
`ifdef DMA_JOB_ARB_PRIO_EN
    .prio_i         (prio),
`endif
    .rsp_o          (rsp),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .be_req_o       (be_req),
    .be_valid_o     (be_valid),
    .be_ready_i     (be_ready),
    .be_rsp_i       (be_rsp),
    .be_rsp_valid_i (be_rsp_valid),
    .be_rsp_ready_o (be_rsp_ready),
    .busy_o         (busy),
    .inflight_o     (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    req_valid    = '0;
    be_ready     = 1'b0;
    be_rsp_valid = 1'b0;
    be_rsp       = '0;
    rsp_ready    = '0;
    prio         = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NumReq; i++) req[i] = 16'(16'h1111 * (i + 1));
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (be_valid !== 1'b0) begin fails++; $display("FAIL reset_be_valid got %b want 0", be_valid); end
    checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    checks++; if (be_rsp_ready !== 1'b0) begin fails++; $display("FAIL reset_be_rsp_ready got %b want 0", be_rsp_ready); end
    checks++; if (busy !== 4'b0) begin fails++; $display("FAIL reset_busy got %b want 0000", busy); end
    checks++; if (inflight !== 4'd0) begin fails++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    rst_n = 1'b1;
  endtask

  // All requesters valid, backend always ready, response one cycle later.
  task automatic test_round_robin();
    logic [3:0] exp_v;
    int g;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = 4'hF; be_ready = 1'b1; rsp_ready = 4'hF;
      be_rsp_valid = (k > 0); be_rsp = 16'(16'h5000 + k);
      #1;
      g = k % 4;
      exp_v = 4'b0001 << g;
      checks++; if (req_ready !== exp_v) begin fails++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, exp_v); end
      checks++; if (be_req !== 16'(16'h1111 * (g + 1))) begin fails++; $display("FAIL rr_payload k=%0d got %h want %h", k, be_req, 16'(16'h1111 * (g + 1))); end
      checks++; if (inflight !== ((k == 0) ? 4'd0 : 4'd1)) begin fails++; $display("FAIL rr_inflight k=%0d got %0d", k, inflight); end
      if (k > 0) begin
        exp_v = 4'b0001 << ((k - 1) % 4);
        checks++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL rr_rsp_owner k=%0d got %b want %b", k, rsp_valid, exp_v); end
        checks++; if (rsp !== 16'(16'h5000 + k)) begin fails++; $display("FAIL rr_rsp_data k=%0d got %h want %h", k, rsp, 16'(16'h5000 + k)); end
      end
    end
    @(negedge clk);
    req_valid = 4'h0; be_rsp_valid = 1'b1;
    #1;
    checks++; if (rsp_valid !== 4'b1000) begin fails++; $display("FAIL rr_last_rsp got %b want 1000", rsp_valid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (inflight !== 4'd0) begin fails++; $display("FAIL rr_drained got %0d want 0", inflight); end
  endtask

  // Stalled grant to req1 must not be preempted; pointer then moves to 2.
  task automatic test_grant_lock();
    @(negedge clk);
    req_valid = 4'b0010; be_ready = 1'b0;
    #1;
    checks++; if (be_valid !== 1'b1) begin fails++; $display("FAIL lock_valid got %b want 1", be_valid); end
    checks++; if (be_req !== 16'h2222) begin fails++; $display("FAIL lock_payload0 got %h want 2222", be_req); end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'b0111; be_ready = 1'b0;
      #1;
      checks++; if (be_req !== 16'h2222 || be_valid !== 1'b1) begin fails++; $display("FAIL lock_hold k=%0d got %h/%b want 2222/1", k, be_req, be_valid); end
      checks++; if (req_ready !== 4'b0) begin fails++; $display("FAIL lock_no_ready k=%0d got %b want 0000", k, req_ready); end
    end
    @(negedge clk);
    be_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL lock_accept got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL lock_next_grant got %b want 0100", req_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (inflight !== 4'd2) begin fails++; $display("FAIL lock_inflight got %0d want 2", inflight); end
    checks++; if (busy !== 4'b0110) begin fails++; $display("FAIL lock_busy got %b want 0110", busy); end
    @(negedge clk);
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    #1;
    checks++; if (rsp_valid !== 4'b0010) begin fails++; $display("FAIL lock_rsp0 got %b want 0010", rsp_valid); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 4'b0100) begin fails++; $display("FAIL lock_rsp1 got %b want 0100", rsp_valid); end
    @(negedge clk);
    drive_idle();
  endtask

  // Ten jobs offered with no responses: eight fit; a pop frees a slot next cycle.
  task automatic test_full();
    logic [3:0] exp_v;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid = 4'hF; be_ready = 1'b1;
      #1;
      exp_v = (k < 8) ? (4'b0001 << ((3 + k) % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_v) begin fails++; $display("FAIL full_grant k=%0d got %b want %b", k, req_ready, exp_v); end
      checks++; if (inflight !== 4'((k < 8) ? k : 8)) begin fails++; $display("FAIL full_inflight k=%0d got %0d", k, inflight); end
      if (k >= 8) begin
        checks++; if (be_valid !== 1'b0) begin fails++; $display("FAIL full_be_valid k=%0d got %b want 0", k, be_valid); end
      end
    end
    @(negedge clk);
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    #1;
    checks++; if (rsp_valid !== 4'b1000) begin fails++; $display("FAIL full_pop_owner got %b want 1000", rsp_valid); end
    checks++; if (req_ready !== 4'b0 || be_valid !== 1'b0) begin fails++; $display("FAIL full_no_bypass got %b/%b want 0000/0", req_ready, be_valid); end
    @(negedge clk);
    be_rsp_valid = 1'b0;
    #1;
    checks++; if (inflight !== 4'd7) begin fails++; $display("FAIL full_after_pop got %0d want 7", inflight); end
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL full_resume got %b want 1000", req_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (inflight !== 4'd8 || busy !== 4'hF) begin fails++; $display("FAIL full_refill got %0d/%b want 8/1111", inflight, busy); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      be_rsp_valid = 1'b1; rsp_ready = 4'hF;
      #1;
      exp_v = 4'b0001 << (k % 4);
      checks++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL full_drain k=%0d got %b want %b", k, rsp_valid, exp_v); end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (inflight !== 4'd0 || busy !== 4'b0) begin fails++; $display("FAIL full_empty got %0d/%b want 0/0000", inflight, busy); end
  endtask

  // Head owned by req3 held off by its rsp_ready for four cycles.
  task automatic test_rsp_backpressure();
    @(negedge clk);
    req_valid = 4'b1000; be_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL bp_accept got %b want 1000", req_ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_idle();
      be_rsp_valid = 1'b1; be_rsp = 16'hBEEF; rsp_ready = 4'b0111;
      #1;
      checks++; if (be_rsp_ready !== 1'b0) begin fails++; $display("FAIL bp_hold k=%0d got %b want 0", k, be_rsp_ready); end
      checks++; if (rsp_valid !== 4'b1000 || rsp !== 16'hBEEF) begin fails++; $display("FAIL bp_rsp k=%0d got %b/%h want 1000/beef", k, rsp_valid, rsp); end
      checks++; if (busy !== 4'b1000) begin fails++; $display("FAIL bp_busy k=%0d got %b want 1000", k, busy); end
    end
    @(negedge clk);
    rsp_ready = 4'hF;
    #1;
    checks++; if (be_rsp_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %b want 1", be_rsp_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (busy !== 4'b0 || inflight !== 4'd0) begin fails++; $display("FAIL bp_cleared got %b/%0d want 0000/0", busy, inflight); end
  endtask

  // Spurious backend response with nothing in flight must not be accepted.
  task automatic test_empty_rsp();
    @(negedge clk);
    be_rsp_valid = 1'b1; rsp_ready = 4'hF;
    #1;
    checks++; if (be_rsp_ready !== 1'b0) begin fails++; $display("FAIL empty_ready got %b want 0", be_rsp_ready); end
    checks++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL empty_valid got %b want 0000", rsp_valid); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (inflight !== 4'd0) begin fails++; $display("FAIL empty_inflight got %0d want 0", inflight); end
  endtask

`ifdef DMA_JOB_ARB_PRIO_EN
  // Priority set wins repeatedly; clearing it resumes round-robin at 3.
  task automatic test_prio();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 4'hF; be_ready = 1'b1; prio = 4'b0100;
      #1;
      checks++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL prio_grant k=%0d got %b want 0100", k, req_ready); end
    end
    @(negedge clk);
    prio = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL prio_resume0 got %b want 1000", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL prio_resume1 got %b want 0001", req_ready); end
    @(negedge clk);
    drive_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_grant_lock();
    test_full();
    test_rsp_backpressure();
    test_empty_rsp();
`ifdef DMA_JOB_ARB_PRIO_EN
    test_prio();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
